// File: rtl/mm_pkg.sv
// mm_pkg: definitions shared by the matrix-multiplier top and its
// operand/result memories.
//   MM_DATA_W    default word width
//   MM_DEPTH     default number of matrix entries per memory
//   fill_state_e fill-engine state encoding (FILL, IDLE)
package mm_pkg;

  localparam int MM_DATA_W = 32;
  localparam int MM_DEPTH  = 100;

  typedef enum logic {
    FILL = 1'b0,
    IDLE = 1'b1
  } fill_state_e;

endpackage

// File: rtl/mem_fill_ctrl.sv
// mem_fill_ctrl: fill engine for matrix_data_mem. After reset, and after an
// accepted clear request, it walks fill_ptr from 0 to DEPTH-1. One entry is
// written per cycle, and then the engine settles in IDLE.
//
// state | meaning
// FILL  | writing INIT_VAL to mem[fill_ptr]; user accesses blocked
// IDLE  | array initialised; user reads/writes accepted
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   clr_req_i    refill request, honoured only in IDLE
//   busy_o       high while in FILL
//   init_done_o  high once a fill has completed, low during any fill
//   fill_we_o    array write strobe for the fill engine
//   fill_addr_o  array address written by the fill engine
//   clr_accept_o clr_req_i was taken this cycle (clears the storage flags)
module mem_fill_ctrl
  import mm_pkg::*;
#(
  parameter int DEPTH  = MM_DEPTH,
  parameter int ADDR_W = 7
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_req_i,
  output logic              busy_o,
  output logic              init_done_o,
  output logic              fill_we_o,
  output logic [ADDR_W-1:0] fill_addr_o,
  output logic              clr_accept_o
);

  // The fill ends on an explicit compare with the last index, so the
  // pointer never has to wrap. This keeps a non-power-of-two DEPTH safe.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] fill_ptr_q, fill_ptr_d;
  logic              init_done_q, init_done_d;
  logic              clr_accept;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= FILL;
      fill_ptr_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_ptr_q  <= fill_ptr_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_ptr_d  = fill_ptr_q;
    init_done_d = init_done_q;
    clr_accept  = 1'b0;
    case (state_q)
      FILL: begin
        if (fill_ptr_q == LAST_ADDR) begin
          state_d     = IDLE;
          fill_ptr_d  = '0;
          init_done_d = 1'b1;
        end else begin
          fill_ptr_d = fill_ptr_q + 1'b1;
        end
      end
      IDLE: begin
        if (clr_req_i) begin
          state_d     = FILL;
          fill_ptr_d  = '0;
          init_done_d = 1'b0;
          clr_accept  = 1'b1;
        end
      end
      default: begin
        state_d    = FILL;
        fill_ptr_d = '0;
      end
    endcase
  end

  assign busy_o       = (state_q == FILL);
  assign init_done_o  = init_done_q;
  assign fill_we_o    = (state_q == FILL);
  assign fill_addr_o  = fill_ptr_q;
  assign clr_accept_o = clr_accept;

endmodule

// File: rtl/matrix_data_mem.sv
// matrix_data_mem: single-clock operand memory for the matrix multiplier.
// It has one write port and one read port, with a read latency of 0 or 1.
// An internal fill engine loads INIT_VAL into every entry after reset and
// on clr_req. Accesses with an address >= DEPTH set a sticky oob_err flag.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   clr_req    refill with INIT_VAL and clear oob_err (ignored while busy)
//   busy       fill engine running
//   init_done  fill completed, low during any fill
//   wr_en      write strobe
//   wr_addr    write address
//   wr_data    write data
//   rd_en      read strobe
//   rd_addr    read address
//   rd_data    read data (0 for an out-of-range read)
//   rd_valid   qualifies rd_data
//   oob_err    sticky out-of-range access flag
module matrix_data_mem
  import mm_pkg::*;
#(
  parameter int                DATA_W   = MM_DATA_W,
  parameter int                DEPTH    = MM_DEPTH,
  parameter int                ADDR_W   = 7,
  parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(1),
  parameter int                READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              init_done,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              oob_err
);

  logic              fill_we;
  logic [ADDR_W-1:0] fill_addr;
  logic              clr_accept;

  mem_fill_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fill (
    .clk_i        (clk),
    .rst_ni       (rst),
    .clr_req_i    (clr_req),
    .busy_o       (busy),
    .init_done_o  (init_done),
    .fill_we_o    (fill_we),
    .fill_addr_o  (fill_addr),
    .clr_accept_o (clr_accept)
  );

  // The range compares are done at 32 bits, so DEPTH == 2**ADDR_W does not
  // truncate to zero.
  logic wr_in_range, rd_in_range;
  assign wr_in_range = (32'(wr_addr) < 32'(DEPTH));
  assign rd_in_range = (32'(rd_addr) < 32'(DEPTH));

  logic wr_accept, rd_accept;
  assign wr_accept = wr_en & ~busy;
  assign rd_accept = rd_en & ~busy;

  // Storage has no reset; the fill engine initialises it.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[fill_addr] <= INIT_VAL;
    end else if (wr_accept && wr_in_range) begin
      mem[wr_addr] <= wr_data;
    end
  end

  logic [DATA_W-1:0] rd_word;
  assign rd_word = rd_in_range ? mem[rd_addr] : '0;

  generate
    if (READ_LAT == 0) begin : g_rd_comb
      // While busy, rd_data is held at its reset value of 0. This stops it
      // from showing entries that are only partly filled.
      assign rd_data  = busy ? '0 : rd_word;
      assign rd_valid = rd_accept & rd_in_range;
    end else begin : g_rd_reg
      logic [DATA_W-1:0] rd_data_q, rd_data_d;
      logic              rd_valid_q, rd_valid_d;

      always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (rd_accept) begin
          rd_data_d  = rd_word;
          rd_valid_d = 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

  logic oob_hit;
  logic oob_q, oob_d;
  assign oob_hit = (wr_accept & ~wr_in_range) | (rd_accept & ~rd_in_range);

  // An accepted clear takes priority over a simultaneous out-of-range hit.
  always_comb begin
    oob_d = oob_q;
    if (clr_accept) begin
      oob_d = 1'b0;
    end else if (oob_hit) begin
      oob_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oob_q <= 1'b0;
    end else begin
      oob_q <= oob_d;
    end
  end

  assign oob_err = oob_q;

endmodule

// File: tb/tb_matrix_data_mem.sv
module tb_matrix_data_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_req;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [6:0]  rd_addr;

  logic        busy1, init_done1, rd_valid1, oob1;
  logic [31:0] rd_data1;
  logic        busy0, init_done0, rd_valid0, oob0;
  logic [31:0] rd_data0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_data_mem #(.READ_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1), .init_done(init_done1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .oob_err(oob1)
  );

  matrix_data_mem #(.READ_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0), .init_done(init_done0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .oob_err(oob0)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic        we;
    logic [6:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [6:0]  ra;
    logic        ev;
    logic [31:0] ed;
    logic        eoob;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
  endtask

  // Called just after a negedge. It drives one cycle, checks the lat-0
  // output in that cycle and the lat-1 output one cycle later.
  task automatic step(input logic we, input logic [6:0] wa, input logic [31:0] wd,
                      input logic re, input logic [6:0] ra,
                      input logic ev, input logic [31:0] ed);
    exp_t e;
    wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
    #1;
    if (re) begin
      chk("rd_valid lat0", rd_valid0, ev & (ra < 7'd100));
      if (ev) chk("rd_data lat0", rd_data0, ed);
    end
    e.v = re & ev;
    e.d = ed;
    sb.push_back(e);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    e = sb.pop_front();
    chk("rd_valid lat1", rd_valid1, e.v);
    if (e.v) chk("rd_data lat1", rd_data1, e.d);
  endtask

  // Counts the negedge samples with busy high, up to stop_at. In cycles
  // drop_lo..drop_hi-1 it also drives a write and a read of address 20.
  task automatic watch_fill(input int stop_at, input int drop_lo, input int drop_hi,
                            output int n);
    logic prev_re;
    n = 0;
    while (busy1 && n < stop_at) begin
      n++;
      if (n >= drop_lo && n < drop_hi) begin
        wr_en = 1'b1; wr_addr = 7'd20; wr_data = 32'h0000ABCD; rd_en = 1'b1; rd_addr = 7'd20;
      end else begin
        wr_en = 1'b0; rd_en = 1'b0;
      end
      #1;
      if (rd_en) chk("rd_valid lat0 during fill", rd_valid0, 1'b0);
      prev_re = rd_en;
      @(negedge clk);
      if (prev_re) chk("rd_valid lat1 during fill", rd_valid1, 1'b0);
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0]  = '{1'b0, 7'd0,   32'h0,        1'b1, 7'd0,   1'b1, 32'h1,        1'b0};
    vecs[1]  = '{1'b0, 7'd0,   32'h0,        1'b1, 7'd57,  1'b1, 32'h1,        1'b0};
    vecs[2]  = '{1'b0, 7'd0,   32'h0,        1'b1, 7'd99,  1'b1, 32'h1,        1'b0};
    vecs[3]  = '{1'b1, 7'd42,  32'hDEADBEEF, 1'b0, 7'd0,   1'b0, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 7'd0,   32'h0,        1'b1, 7'd42,  1'b1, 32'hDEADBEEF, 1'b0};
    vecs[5]  = '{1'b1, 7'd10,  32'h5,        1'b1, 7'd10,  1'b1, 32'h1,        1'b0};
    vecs[6]  = '{1'b0, 7'd0,   32'h0,        1'b1, 7'd10,  1'b1, 32'h5,        1'b0};
    vecs[7]  = '{1'b0, 7'd0,   32'h0,        1'b0, 7'd0,   1'b0, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 7'd100, 32'h77,       1'b0, 7'd0,   1'b0, 32'h0,        1'b1};
    vecs[9]  = '{1'b0, 7'd0,   32'h0,        1'b1, 7'd127, 1'b1, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 7'd0,   32'h0,        1'b1, 7'd99,  1'b1, 32'h1,        1'b1};
    vecs[11] = '{1'b0, 7'd0,   32'h0,        1'b1, 7'd42,  1'b1, 32'hDEADBEEF, 1'b1};

    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", busy1, 1'b1);
    chk("reset busy lat0", busy0, 1'b1);
    chk("reset init_done", init_done1, 1'b0);
    chk("reset rd_valid", rd_valid1, 1'b0);
    chk("reset rd_data", rd_data1, 32'h0);
    chk("reset rd_valid lat0", rd_valid0, 1'b0);
    chk("reset oob_err", oob1, 1'b0);

    rst = 1'b1;
    watch_fill(1000, 0, 0, n);
    chk("initial fill cycles", n, 100);
    chk("init_done after fill", init_done1, 1'b1);
    chk("init_done lat0 after fill", init_done0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra, vecs[i].ev, vecs[i].ed);
      chk($sformatf("oob_err vec%0d", i), oob1, vecs[i].eoob);
      chk($sformatf("oob_err lat0 vec%0d", i), oob0, vecs[i].eoob);
    end

    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    chk("clr busy", busy1, 1'b1);
    chk("clr init_done", init_done1, 1'b0);
    chk("clr oob_err", oob1, 1'b0);
    chk("clr oob_err lat0", oob0, 1'b0);
    watch_fill(1000, 0, 0, n);
    chk("clr fill cycles", n, 100);
    step(1'b0, 7'd0, 32'h0, 1'b1, 7'd42, 1'b1, 32'h1);
    step(1'b0, 7'd0, 32'h0, 1'b1, 7'd10, 1'b1, 32'h1);

    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    watch_fill(50, 10, 15, n);
    chk("fill cycles before abort", n, 50);
    rst = 1'b0;
    #1;
    chk("abort busy", busy1, 1'b1);
    chk("abort init_done", init_done1, 1'b0);
    chk("abort rd_data", rd_data1, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    watch_fill(1000, 60, 65, n);
    chk("restarted fill cycles", n, 100);
    chk("init_done after restart", init_done1, 1'b1);
    step(1'b0, 7'd0, 32'h0, 1'b1, 7'd20, 1'b1, 32'h1);
    step(1'b0, 7'd0, 32'h0, 1'b1, 7'd99, 1'b1, 32'h1);
    chk("oob_err after restart", oob1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
